instr_fetch: RTL and testbench

- Fetch stage directly downstream of the PC block.
- Takes the current PC and issues a word read to instruction memory over a req/ack handshake.
- Registers the returned instruction for decode.
- Pulses iready back to the PC block so it advances exactly once per completed fetch.
- Handles mid-fetch redirects (flush), decode stalls, misaligned PCs and memory timeouts.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/instr_fetch_if.sv | 23 ++
 rtl/fetch_timer.sv | 29 ++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: a request is held until the memory acks it.
interface instr_fetch_if;

  logic                      mem_req;
  logic [fetch_pkg::XLEN-1:0] mem_addr;
  logic [fetch_pkg::XLEN-1:0] mem_rdata;
  logic                      mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/fetch_timer.sv
// Saturating wait-cycle counter; tc flags the last permitted cycle without an ack.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 5) ? $clog2(TIMEOUT_CYCLES) + 1 : 5;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TOP  = '1;

  logic [CW-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != TOP) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one word read per accepted PC and registers the result for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              TIMEOUT_CYCLES = 16,
  parameter logic [XLEN-1:0] RESET_INSTR    = NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc,
  input  logic                fetch_en,
  input  logic                stall,
  input  logic                flush,
  instr_fetch_if.master       mem,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic                iready,
  output logic                fetch_fault,
  output logic                busy
);

  fetch_state_t state;
  logic         flush_seen;
  logic         accept;
  logic         misaligned;
  logic         timer_en;
  logic         timer_tc;

  assign accept     = (state == IDLE) && fetch_en && !stall && !flush;
  assign misaligned = (pc[1:0] != 2'b00);
  assign timer_en   = (state == WAIT) && !mem.mem_ack;
  assign busy       = (state != IDLE);

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      instr        <= RESET_INSTR;
      instr_pc     <= '0;
      iready       <= 1'b0;
      fetch_fault  <= 1'b0;
      flush_seen   <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a branch below raises them.
      iready      <= 1'b0;
      fetch_fault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              mem.mem_addr <= pc;
              mem.mem_req  <= 1'b1;
              flush_seen   <= 1'b0;
              state        <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) flush_seen <= 1'b1;
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            state       <= IDLE;
            // A redirect seen at any point of the fetch makes the returned word stale.
            if (!flush_seen && !flush) begin
              instr    <= mem.mem_rdata;
              instr_pc <= mem.mem_addr;
              iready   <= 1'b1;
            end
          end else if (timer_tc) begin
            mem.mem_req <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end
        end
        FAULT: begin
          instr <= RESET_INSTR;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized fetch transactions checked against a transaction-level model.
module tb_instr_fetch;

  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        tb_clk = 1'b0;
  logic        rst, fetch_en, stall, flush;
  logic [31:0] pc;
  logic [31:0] instr, instr_pc;
  logic        iready, fetch_fault, busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;

  always #5 tb_clk = ~tb_clk;

  instr_fetch_if mem_bus ();

  instr_fetch #(
    .TIMEOUT_CYCLES(TO),
    .RESET_INSTR   (NOP)
  ) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .flush       (flush),
    .mem         (mem_bus),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .iready      (iready),
    .fetch_fault (fetch_fault),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch of address a; memory acks in wait cycle lat, flush pulses in cycle flush_at (-1 = none).
  task automatic run_fetch(input string tag, input logic [31:0] a, input int lat,
                           input int flush_at, input logic [31:0] data);
    int req_n, rdy_n, flt_n, both_n, addr_bad;
    bit aligned, discard;
    req_n = 0; rdy_n = 0; flt_n = 0; both_n = 0; addr_bad = 0;
    aligned = (a[1:0] == 2'b00);
    pc = a; fetch_en = 1'b1; stall = 1'b0; flush = 1'b0;
    @(negedge tb_clk);
    fetch_en = 1'b0;
    check({tag, ":req_rise"}, {31'b0, mem_bus.mem_req}, {31'b0, aligned});
    for (int c = 0; c < TO + 4; c++) begin
      if (mem_bus.mem_req) begin
        req_n++;
        if (mem_bus.mem_addr !== a) addr_bad++;
      end
      if (iready) rdy_n++;
      if (fetch_fault) flt_n++;
      if (iready && fetch_fault) both_n++;
      mem_bus.mem_ack   = (c == lat);
      mem_bus.mem_rdata = (c == lat) ? data : $urandom;
      flush             = (c == flush_at);
      stall             = 1'($urandom_range(0, 1));
      @(negedge tb_clk);
    end
    mem_bus.mem_ack = 1'b0; flush = 1'b0; stall = 1'b0;

    discard = (flush_at >= 0) && (flush_at <= lat);
    if (!aligned) begin
      check({tag, ":req_cycles"}, req_n, 0);
      check({tag, ":faults"}, flt_n, 1);
      check({tag, ":readies"}, rdy_n, 0);
      exp_instr = NOP;
    end else if (lat >= TO) begin
      check({tag, ":req_cycles"}, req_n, TO);
      check({tag, ":faults"}, flt_n, 1);
      check({tag, ":readies"}, rdy_n, 0);
      exp_instr = NOP;
    end else begin
      check({tag, ":req_cycles"}, req_n, lat + 1);
      check({tag, ":faults"}, flt_n, 0);
      check({tag, ":readies"}, rdy_n, discard ? 0 : 1);
      if (!discard) begin
        exp_instr = data;
        exp_pc    = a;
      end
    end
    check({tag, ":addr_bad"}, addr_bad, 0);
    check({tag, ":overlap"}, both_n, 0);
    check({tag, ":instr"}, instr, exp_instr);
    check({tag, ":instr_pc"}, instr_pc, exp_pc);
    check({tag, ":busy_end"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_bad;
    logic [31:0] a;
    rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    exp_instr = NOP; exp_pc = '0;

    // Power-on reset
    repeat (2) @(negedge tb_clk);
    check("rst:mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst:mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst:instr", instr, NOP);
    check("rst:instr_pc", instr_pc, 32'd0);
    check("rst:iready", {31'b0, iready}, 32'd0);
    check("rst:fault", {31'b0, fetch_fault}, 32'd0);
    check("rst:busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // Basic fetch
    run_fetch("basic", 32'h100, 2, -1, 32'h00A0_0093);
    check("basic:instr_const", instr, 32'h00A0_0093);

    // Flush one cycle before ack, then a clean fetch
    run_fetch("flush", 32'h200, 2, 1, 32'hDEAD_BEEF);
    check("flush:instr_const", instr, 32'h00A0_0093);
    run_fetch("after_flush", 32'h300, 1, -1, 32'h1234_5678);

    // Stall holds off acceptance
    stall = 1'b1; fetch_en = 1'b1; pc = 32'h10; stall_bad = 0;
    repeat (5) begin
      @(negedge tb_clk);
      if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0) stall_bad++;
    end
    check("stall:held", stall_bad, 0);
    run_fetch("stall_rel", 32'h10, 0, -1, 32'h0010_0113);

    // Misaligned PC and memory timeout
    run_fetch("misaligned", 32'h102, 0, -1, 32'hFFFF_FFFF);
    run_fetch("timeout", 32'h400, TO + 1, -1, 32'hBAD0_BAD0);

    // Reset in the middle of a fetch; late ack must be ignored
    pc = 32'h40; fetch_en = 1'b1;
    @(negedge tb_clk);
    fetch_en = 1'b0;
    check("rst_mid:busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    exp_instr = NOP; exp_pc = '0;
    check("rst_mid:mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_mid:instr", instr, NOP);
    check("rst_mid:instr_pc", instr_pc, 32'd0);
    check("rst_mid:busy", {31'b0, busy}, 32'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge tb_clk);
    mem_bus.mem_ack = 1'b0;
    check("rst_mid:late_ack_iready", {31'b0, iready}, 32'd0);
    check("rst_mid:late_ack_instr", instr, NOP);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      int lat, fl;
      a = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      lat = $urandom_range(0, TO + 1);
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : -1;
      run_fetch($sformatf("rand%0d", i), a, lat, fl, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
